addsub_accumulator: RTL and testbench

//  - Downstream stage of the 4-bit adder/subtractor. Consumes its {mode, cy, f[3:0]} result stream.
//  - Converts each result to a signed value and accumulates BURST results into a signed accumulator.
//  - Emits one accumulated word per burst, with a valid/ready handshake and an overflow flag.

---
 rtl/addsub_pkg.sv | 41 ++++
 rtl/addsub_operand_decode.sv | 20 ++
 rtl/addsub_accumulator.sv | 118 +++++++++++
 tb/tb_addsub_accumulator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and arithmetic for the add/sub result accumulator.
// ADDSUB_ACC_SATURATE_EN selects clamping instead of wrapping in sat_add.
package addsub_pkg;

   localparam int unsigned OPW   = 4;
   localparam int unsigned VAL_W = OPW + 2;
   localparam int unsigned WIDE_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      EMIT = 2'd2
   } state_t;

   typedef struct packed {
      logic                     ovf;
      logic signed [WIDE_W-1:0] sum;
   } sat_res_t;

   // Signed add checked against a w-bit two's complement range; the
   // returned sum is either clamped or left for the caller to truncate.
   function automatic sat_res_t sat_add(input logic signed [WIDE_W-1:0] a,
                                        input logic signed [WIDE_W-1:0] b,
                                        input int unsigned w = 12);
      sat_res_t               r;
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.sum = a + b;
      r.ovf = (r.sum > hi) || (r.sum < lo);
`ifdef ADDSUB_ACC_SATURATE_EN
      if (r.sum > hi)
         r.sum = hi;
      else if (r.sum < lo)
         r.sum = lo;
`endif
      return r;
   endfunction

endpackage

// File: rtl/addsub_operand_decode.sv
// Maps one {mode, cy, f} adder/subtractor result to a signed value.
module addsub_operand_decode
   import addsub_pkg::*;
(
   input  logic                    mode,
   input  logic                    cy,
   input  logic [OPW-1:0]          f,
   output logic signed [VAL_W-1:0] val
);

   logic signed [VAL_W-1:0] mag;

   always_comb begin
      mag = signed'({2'b00, f});
      val = signed'({1'b0, cy, f});
      if (mode)
         val = cy ? -mag : mag;
   end

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulates BURST decoded add/sub results into one signed word per burst.
// ADDSUB_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module addsub_accumulator
   import addsub_pkg::*;
#(
   parameter int unsigned ACC_W = 12,
   parameter int unsigned BURST = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic                    in_cy,
   input  logic [OPW-1:0]          in_f,
   input  logic                    clr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_acc,
   output logic                    out_ovf
);

   localparam int unsigned CNT_W = $clog2(BURST + 1);

   state_t                  state, state_d;
   logic signed [ACC_W-1:0] acc, acc_d;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic                    ovf, ovf_d;
   logic                    run;
   logic                    accept;
   logic signed [VAL_W-1:0] val;
   sat_res_t                add_res;
   logic                    unused_sum_hi;

   addsub_operand_decode u_decode (
      .mode (in_mode),
      .cy   (in_cy),
      .f    (in_f),
      .val  (val)
   );

   // run holds in_ready low until the first clock after reset releases
   assign in_ready      = run && (state != EMIT) && !clr && !rst;
   assign accept        = in_valid && in_ready;
   assign add_res       = sat_add(WIDE_W'(acc), WIDE_W'(val), ACC_W);
   assign unused_sum_hi = ^add_res.sum[WIDE_W-1:ACC_W];

   always_comb begin
      state_d = state;
      acc_d   = acc;
      cnt_d   = cnt;
      ovf_d   = ovf;
      case (state)
         IDLE: begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            if (accept) begin
               acc_d   = ACC_W'(val);
               cnt_d   = CNT_W'(1);
               state_d = (BURST == 1) ? EMIT : ACC;
            end
         end
         ACC: begin
            if (clr) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else if (accept) begin
               acc_d = ACC_W'(add_res.sum);
               ovf_d = ovf | add_res.ovf;
               cnt_d = cnt + CNT_W'(1);
               if (cnt_d == CNT_W'(BURST))
                  state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
         end
      endcase
   end

   // Output registers mirror the next state so out_valid rises right after the last accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         run       <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
      end else begin
         state     <= state_d;
         acc       <= acc_d;
         cnt       <= cnt_d;
         ovf       <= ovf_d;
         run       <= 1'b1;
         out_valid <= (state_d == EMIT);
         out_acc   <= (state_d == EMIT) ? acc_d : '0;
         out_ovf   <= (state_d == EMIT) && ovf_d;
      end
   end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench: two accumulators (12-bit and 8-bit) share one stimulus stream.
module tb_addsub_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_mode = 1'b0;
   logic       in_cy = 1'b0;
   logic [3:0] in_f = 4'h0;
   logic       clr = 1'b0;
   logic       out_ready = 1'b0;

   logic        in_ready_a, in_ready_b;
   logic        out_valid_a, out_valid_b;
   logic        out_ovf_a, out_ovf_b;
   logic [11:0] out_acc_a;
   logic [7:0]  out_acc_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   addsub_accumulator #(.ACC_W(12), .BURST(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_mode(in_mode), .in_cy(in_cy), .in_f(in_f), .clr(clr),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_acc(out_acc_a), .out_ovf(out_ovf_a)
   );

   addsub_accumulator #(.ACC_W(8), .BURST(8)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_mode(in_mode), .in_cy(in_cy), .in_f(in_f), .clr(clr),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_acc(out_acc_b), .out_ovf(out_ovf_b)
   );

   typedef struct {
      logic       mode;
      logic       cy;
      logic [3:0] f;
      int         exp_a;
      bit         ovf_a;
      int         exp_b;
      bit         ovf_b;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer accumulation with range check on every add
   function automatic void ref_burst(input int v[8], input int w, output int acc, output bit ovf);
      int hi, lo;
      hi  = (1 << (w - 1)) - 1;
      lo  = -(1 << (w - 1));
      acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
         acc += v[i];
         if (acc > hi || acc < lo) begin
            ovf = 1'b1;
`ifdef ADDSUB_ACC_SATURATE_EN
            acc = (acc > hi) ? hi : lo;
`else
            acc = (acc > hi) ? acc - (1 << w) : acc + (1 << w);
`endif
         end
      end
   endfunction

   // Entered and left at posedge+1
   task automatic send(input logic m, input logic c, input logic [3:0] f);
      int waited = 0;
      bit got = 1'b0;
      in_mode = m; in_cy = c; in_f = f; in_valid = 1'b1;
      while (!got && waited <= 40) begin
         @(negedge clk);
         if (in_ready_a) got = 1'b1;
         else begin
            waited++;
            @(posedge clk); #1;
         end
      end
      if (got) begin
         @(posedge clk); #1;
      end else begin
         checks++; failures++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_n(input logic m, input logic c, input logic [3:0] f, input int n);
      for (int i = 0; i < n; i++) send(m, c, f);
   endtask

   task automatic drain(input string name, input int ea, input bit oa, input int eb, input bit ob);
      int waited = 0;
      @(negedge clk);
      while (!out_valid_a && waited < 40) begin
         waited++;
         @(negedge clk);
      end
      chk({name, "_valid"}, longint'(out_valid_a & out_valid_b), 1);
      chk({name, "_acc12"}, $signed(out_acc_a), ea);
      chk({name, "_ovf12"}, out_ovf_a, oa);
      chk({name, "_acc8"}, $signed(out_acc_b), eb);
      chk({name, "_ovf8"}, out_ovf_b, ob);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   initial begin
      int  v[8];
      int  ea, eb;
      bit  oa, ob;
      bit  stale;
      logic m, c;
      logic [3:0] f;

      vecs[0] = '{1'b0, 1'b0, 4'hA,   80, 1'b0,   80, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 4'h5,  -40, 1'b0,  -40, 1'b0};
`ifdef ADDSUB_ACC_SATURATE_EN
      vecs[2] = '{1'b0, 1'b1, 4'hF,  248, 1'b0,  127, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 4'h0,  128, 1'b0,  127, 1'b1};
`else
      vecs[2] = '{1'b0, 1'b1, 4'hF,  248, 1'b0,   -8, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 4'h0,  128, 1'b0, -128, 1'b1};
`endif
      vecs[3] = '{1'b1, 1'b0, 4'hF,  120, 1'b0,  120, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 4'hF, -120, 1'b0, -120, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 4'h0,    0, 1'b0,    0, 1'b0};

      // Reset state and in_ready release timing
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid_a, 0);
      chk("rst_acc", out_acc_a, 0);
      chk("rst_ovf", out_ovf_a, 0);
      chk("rst_ready", in_ready_a, 0);
      rst = 1'b0;
      #1 chk("ready_before_clk", in_ready_a, 0);
      @(posedge clk); #1;
      chk("ready_after_clk", longint'(in_ready_a & in_ready_b), 1);

      // T1 with latency check
      send_n(1'b0, 1'b0, 4'hA, 7);
      @(negedge clk);
      chk("t1_not_early", out_valid_a, 0);
      @(posedge clk); #1;
      send(1'b0, 1'b0, 4'hA);
      chk("t1_latency", out_valid_a, 1);
      drain("t1", 80, 1'b0, 80, 1'b0);

      for (int i = 0; i < 7; i++) begin
         send_n(vecs[i].mode, vecs[i].cy, vecs[i].f, 8);
         drain($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].ovf_a, vecs[i].exp_b, vecs[i].ovf_b);
      end

      // T4: backpressure hold
      send_n(1'b0, 1'b0, 4'h1, 8);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", out_valid_a, 1);
         chk("t4_hold_acc", $signed(out_acc_a), 8);
         chk("t4_hold_ready", in_ready_a, 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      chk("t4_released_valid", out_valid_a, 0);
      chk("t4_released_ready", in_ready_a, 1);
      @(posedge clk); #1;

      // T5: clr drops the coincident sample and aborts the burst
      send_n(1'b0, 1'b0, 4'h3, 3);
      clr = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_cy = 1'b0; in_f = 4'h7;
      @(negedge clk);
      chk("t5_clr_ready", in_ready_a, 0);
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0;
      send_n(1'b1, 1'b0, 4'h2, 8);
      drain("t5", 16, 1'b0, 16, 1'b0);

      // T6a: async reset mid-burst
      send_n(1'b0, 1'b0, 4'h5, 3);
      #2 rst = 1'b1;
      #1 chk("t6a_ready", in_ready_a, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      send_n(1'b0, 1'b0, 4'h1, 8);
      drain("t6a", 8, 1'b0, 8, 1'b0);

      // T6b: async reset while a result is pending
      send_n(1'b0, 1'b1, 4'hF, 8);
      @(negedge clk);
      chk("t6b_pending", longint'(out_valid_a & out_ovf_b), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6b_valid", longint'(out_valid_a | out_valid_b), 0);
      chk("t6b_acc", longint'(out_acc_a) | longint'(out_acc_b), 0);
      chk("t6b_ovf", out_ovf_b, 0);
      @(negedge clk) rst = 1'b0;
      stale = 1'b0;
      repeat (4) begin
         @(negedge clk);
         stale |= out_valid_a | out_valid_b;
      end
      chk("t6b_no_stale", stale, 0);
      @(posedge clk); #1;

      // Random bursts against the integer model
      for (int b = 0; b < 30; b++) begin
         for (int i = 0; i < 8; i++) begin
            m = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            f = 4'($urandom_range(0, 15));
            v[i] = m ? (c ? -int'(f) : int'(f)) : (int'(c) * 16 + int'(f));
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            send(m, c, f);
         end
         ref_burst(v, 12, ea, oa);
         ref_burst(v, 8, eb, ob);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         drain($sformatf("rnd%0d", b), ea, oa, eb, ob);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
